// File: rtl/graph_edge_server_pkg.sv
// graph_pkg: types and default widths shared by the graph edge server and
// the traversal controller that drives it.
//   graph_srv_state_t  - edge server FSM state encoding
//   graph_node_entry_t - node-table entry {valid, offset, count} at default widths
//   GRAPH_*            - default widths/depths of the node/edge interface
package graph_pkg;

  localparam int GRAPH_NODE_IDX_W = 10;
  localparam int GRAPH_COUNTER_W  = 4;
  localparam int GRAPH_MAX_EDGES  = 4096;
  localparam int GRAPH_EDGE_AW    = $clog2(GRAPH_MAX_EDGES);
  localparam int GRAPH_STAT_W     = 16;

  typedef enum logic [2:0] {
    ST_LOAD       = 3'd0,
    ST_SERVE_IDLE = 3'd1,
    ST_LOOKUP     = 3'd2,
    ST_STREAM     = 3'd3,
    ST_ERROR      = 3'd4
  } graph_srv_state_t;

  typedef struct packed {
    logic                       valid;
    logic [GRAPH_EDGE_AW-1:0]   offset;
    logic [GRAPH_COUNTER_W-1:0] count;
  } graph_node_entry_t;

endpackage

// File: rtl/graph_edge_server_sync_ram.sv
// sync_ram: single-port RAM with registered read data and write-first
// behaviour (a write returns the written word on rdata the next cycle).
// No reset: contents and read register are pure data.
//   clk   - clock
//   we    - write enable
//   addr  - read/write address
//   wdata - write data
//   rdata - registered read data
module sync_ram
  import graph_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/graph_edge_server.sv
// graph_edge_server: adjacency responder for the path-counting accelerator.
// Loaded once with an edge list grouped by source node, it then answers node
// lookups by streaming every neighbour of the requested node, one beat per
// cycle, each beat tagged with the number of edges remaining (incl. itself).
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   ld_valid/ld_ready  - load beat handshake; ld_src_idx, ld_dst_idx, ld_last
//   req_valid/req_ready- lookup handshake; node_idx is the node to look up
//   rsp_valid/rsp_ready- response handshake; next_node_idx, next_node_counter
//   err                - sticky load error (cleared only by rst)
//
// Optional build macro GRAPH_EDGE_SERVER_STATS_EN adds saturating 16-bit
// counters stat_req_count (accepted requests) and stat_edge_count (accepted
// beats with a nonzero counter).
module graph_edge_server
  import graph_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH = GRAPH_NODE_IDX_W,
  parameter int PARAM_COUNTER_WIDTH  = GRAPH_COUNTER_W,
  parameter int PARAM_MAX_EDGES      = GRAPH_MAX_EDGES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] ld_src_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] ld_dst_idx,
  input  logic                            ld_last,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter,
  output logic                            err
`ifdef GRAPH_EDGE_SERVER_STATS_EN
  ,
  output logic [GRAPH_STAT_W-1:0]         stat_req_count,
  output logic [GRAPH_STAT_W-1:0]         stat_edge_count
`endif
);

  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int CW = PARAM_COUNTER_WIDTH;
  localparam int AW = $clog2(PARAM_MAX_EDGES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [AW:0]   WR_FULL = (AW+1)'(PARAM_MAX_EDGES);

  graph_srv_state_t state_q, state_d;

  // Load-side bookkeeping: write pointer (one extra bit to see "full")
  // and the currently open source group.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic             grp_open_q, grp_open_d;
  logic [NW-1:0]    cur_src_q, cur_src_d;
  logic [AW-1:0]    cur_off_q, cur_off_d;
  logic [CW-1:0]    cur_cnt_q, cur_cnt_d;

  // Valid bits kept in flops so reset clears the whole table at once.
  logic [2**NW-1:0] node_vld_q, node_vld_d;

  // Serve-side state.
  logic             lk_vld_q, lk_vld_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    rem_q, rem_d;

  logic             ld_fire, req_fire, rsp_fire;
  logic             new_grp, ld_err, ld_wr;
  logic [CW-1:0]    grp_cnt;
  logic [AW-1:0]    grp_off;

  logic [NW-1:0]    nt_addr;
  logic [AW+CW-1:0] nt_wdata, nt_rdata;
  logic [AW-1:0]    nt_off;
  logic [CW-1:0]    nt_cnt;
  logic [AW-1:0]    edge_addr;
  logic [NW-1:0]    edge_rdata;

  assign ld_ready  = (state_q == ST_LOAD) && !rst;
  assign req_ready = (state_q == ST_SERVE_IDLE);
  assign rsp_valid = (state_q == ST_STREAM);
  assign err       = (state_q == ST_ERROR);

  assign ld_fire  = ld_valid && ld_ready;
  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // A new group opens on the first beat after reset or on a source change.
  assign new_grp = !grp_open_q || (ld_src_idx != cur_src_q);
  assign grp_cnt = new_grp ? CW'(1) : cur_cnt_q + CW'(1);
  assign grp_off = new_grp ? wr_ptr_q[AW-1:0] : cur_off_q;
  assign ld_err  = (new_grp && node_vld_q[ld_src_idx]) ||
                   (!new_grp && (cur_cnt_q == CNT_MAX)) ||
                   (wr_ptr_q == WR_FULL);
  assign ld_wr   = ld_fire && !ld_err;

  // The node-table entry is rewritten on every beat of its group, so the
  // stored count always tracks the running total without a read-modify-write.
  assign nt_addr  = (state_q == ST_LOAD) ? ld_src_idx : node_idx;
  assign nt_wdata = {grp_off, grp_cnt};
  assign nt_off   = nt_rdata[AW+CW-1:CW];
  assign nt_cnt   = nt_rdata[CW-1:0];

  // Edge RAM is addressed with the next read pointer, so the word for the
  // following beat is already registered when the current one is accepted;
  // during a stall the same address is re-read and the output holds.
  assign edge_addr = (state_q == ST_LOAD) ? wr_ptr_q[AW-1:0] : rd_ptr_d;

  sync_ram #(
    .DATA_W (AW + CW),
    .ADDR_W (NW)
  ) u_node_table (
    .clk   (clk),
    .we    (ld_wr),
    .addr  (nt_addr),
    .wdata (nt_wdata),
    .rdata (nt_rdata)
  );

  sync_ram #(
    .DATA_W (NW),
    .ADDR_W (AW)
  ) u_edge_ram (
    .clk   (clk),
    .we    (ld_wr),
    .addr  (edge_addr),
    .wdata (ld_dst_idx),
    .rdata (edge_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    grp_open_d = grp_open_q;
    cur_src_d  = cur_src_q;
    cur_off_d  = cur_off_q;
    cur_cnt_d  = cur_cnt_q;
    node_vld_d = node_vld_q;
    lk_vld_d   = lk_vld_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;

    unique case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          if (ld_err) begin
            state_d = ST_ERROR;
          end else begin
            wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
            grp_open_d = 1'b1;
            cur_src_d  = ld_src_idx;
            cur_off_d  = grp_off;
            cur_cnt_d  = grp_cnt;
            if (new_grp) node_vld_d[ld_src_idx] = 1'b1;
            if (ld_last) state_d = ST_SERVE_IDLE;
          end
        end
      end
      ST_SERVE_IDLE: begin
        if (req_fire) begin
          lk_vld_d = node_vld_q[node_idx];
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // An unloaded node becomes a single zero-counter beat in STREAM.
        rd_ptr_d = nt_off;
        rem_d    = lk_vld_q ? nt_cnt : '0;
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (rsp_fire) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (rem_q <= CW'(1)) begin
            rem_d   = '0;
            state_d = ST_SERVE_IDLE;
          end else begin
            rem_d = rem_q - CW'(1);
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      wr_ptr_q   <= '0;
      grp_open_q <= 1'b0;
      node_vld_q <= '0;
      lk_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      grp_open_q <= grp_open_d;
      node_vld_q <= node_vld_d;
      lk_vld_q   <= lk_vld_d;
    end
    cur_src_q <= cur_src_d;
    cur_off_q <= cur_off_d;
    cur_cnt_q <= cur_cnt_d;
    rd_ptr_q  <= rd_ptr_d;
    rem_q     <= rem_d;
  end

  assign next_node_idx     = (rsp_valid && (rem_q != '0)) ? edge_rdata : '0;
  assign next_node_counter = rsp_valid ? rem_q : '0;

`ifdef GRAPH_EDGE_SERVER_STATS_EN
  logic [GRAPH_STAT_W-1:0] stat_req_q, stat_req_d;
  logic [GRAPH_STAT_W-1:0] stat_edge_q, stat_edge_d;

  always_comb begin
    stat_req_d  = stat_req_q;
    stat_edge_d = stat_edge_q;
    if (req_fire && (stat_req_q != '1)) stat_req_d = stat_req_q + GRAPH_STAT_W'(1);
    if (rsp_fire && (rem_q != '0) && (stat_edge_q != '1))
      stat_edge_d = stat_edge_q + GRAPH_STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_q  <= '0;
      stat_edge_q <= '0;
    end else begin
      stat_req_q  <= stat_req_d;
      stat_edge_q <= stat_edge_d;
    end
  end

  assign stat_req_count  = stat_req_q;
  assign stat_edge_count = stat_edge_q;
`endif

endmodule

// File: tb/tb_graph_edge_server.sv
// Directed self-checking bench for graph_edge_server (default build).
module tb_graph_edge_server;

  localparam int NW = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [NW-1:0] ld_src_idx = '0;
  logic [NW-1:0] ld_dst_idx = '0;
  logic          ld_last = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NW-1:0] node_idx = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [NW-1:0] next_node_idx;
  logic [CW-1:0] next_node_counter;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  graph_edge_server dut (
    .clk               (clk),
    .rst               (rst),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_src_idx        (ld_src_idx),
    .ld_dst_idx        (ld_dst_idx),
    .ld_last           (ld_last),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .node_idx          (node_idx),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .next_node_idx     (next_node_idx),
    .next_node_counter (next_node_counter),
    .err               (err)
  );

  // {rsp_valid, next_node_idx, next_node_counter}
  function automatic logic [NW+CW:0] beat(input logic v, input int idx, input int cnt);
    return {v, NW'(idx), CW'(cnt)};
  endfunction

  function automatic logic [NW+CW:0] obs();
    return {rsp_valid, next_node_idx, next_node_counter};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_beat(input int src, input int dst, input logic last);
    ld_valid = 1'b1; ld_src_idx = NW'(src); ld_dst_idx = NW'(dst); ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic load_small_graph();
    load_beat(0, 1, 1'b0);
    load_beat(0, 2, 1'b0);
    load_beat(0, 3, 1'b0);
    load_beat(1, 3, 1'b1);
  endtask

  // Drives a request for one cycle; returns at cycle T+1.
  task automatic issue_req(input int n);
    req_valid = 1'b1; node_idx = NW'(n);
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    if ({ld_ready, req_ready, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: ld_ready/req_ready/err=%b required 000", {ld_ready, req_ready, err});
    end
    n_tests++;
    if (obs() !== beat(0, 0, 0)) begin
      n_fail++; $display("FAIL reset_rsp: got %h required %h", obs(), beat(0, 0, 0));
    end
    n_tests++;
    rst = 1'b0;
    #1;
    if ({ld_ready, req_ready, err} !== 3'b100) begin
      n_fail++; $display("FAIL after_reset: ld_ready/req_ready/err=%b required 100", {ld_ready, req_ready, err});
    end
    n_tests++;
    step();
    req_valid = 1'b0;
    if ({ld_ready, req_ready, rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL req_in_load: ld_ready/req_ready/rsp_valid=%b required 100", {ld_ready, req_ready, rsp_valid});
    end
    n_tests++;
  endtask

  task automatic test_stream();
    do_reset();
    load_small_graph();
    if ({ld_ready, req_ready, err} !== 3'b010) begin
      n_fail++; $display("FAIL load_done: ld_ready/req_ready/err=%b required 010", {ld_ready, req_ready, err});
    end
    n_tests++;
    issue_req(0);
    if ({req_ready, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL lookup_cycle: req_ready/rsp_valid=%b required 00", {req_ready, rsp_valid});
    end
    n_tests++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs() !== beat(1, i + 1, 3 - i)) begin
        n_fail++; $display("FAIL stream0_beat%0d: got %h required %h", i, obs(), beat(1, i + 1, 3 - i));
      end
      n_tests++;
    end
    step();
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL stream0_done: req_ready/rsp_valid=%b required 10", {req_ready, rsp_valid});
    end
    n_tests++;
  endtask

  task automatic test_unloaded();
    issue_req(5);
    step();
    if (obs() !== beat(1, 0, 0)) begin
      n_fail++; $display("FAIL unloaded_beat: got %h required %h", obs(), beat(1, 0, 0));
    end
    n_tests++;
    step();
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL unloaded_done: req_ready/rsp_valid=%b required 10", {req_ready, rsp_valid});
    end
    n_tests++;
    issue_req(1);
    step();
    if (obs() !== beat(1, 3, 1)) begin
      n_fail++; $display("FAIL node1_beat: got %h required %h", obs(), beat(1, 3, 1));
    end
    n_tests++;
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    issue_req(0);
    step();
    if (obs() !== beat(1, 1, 3)) begin
      n_fail++; $display("FAIL bp_beat0: got %h required %h", obs(), beat(1, 1, 3));
    end
    n_tests++;
    step();
    if (obs() !== beat(1, 2, 2)) begin
      n_fail++; $display("FAIL bp_beat1: got %h required %h", obs(), beat(1, 2, 2));
    end
    n_tests++;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs() !== beat(1, 2, 2)) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h required %h", i, obs(), beat(1, 2, 2));
      end
      n_tests++;
    end
    rsp_ready = 1'b1;
    step();
    if (obs() !== beat(1, 3, 1)) begin
      n_fail++; $display("FAIL bp_beat2: got %h required %h", obs(), beat(1, 3, 1));
    end
    n_tests++;
    step();
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_done: req_ready/rsp_valid=%b required 10", {req_ready, rsp_valid});
    end
    n_tests++;
  endtask

  task automatic test_regroup_error();
    do_reset();
    load_beat(0, 10, 1'b0);
    load_beat(1, 11, 1'b0);
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL regroup_pre: err=%b required 0", err);
    end
    n_tests++;
    load_beat(0, 12, 1'b1);
    if ({err, ld_ready} !== 2'b10) begin
      n_fail++; $display("FAIL regroup_err: err/ld_ready=%b required 10", {err, ld_ready});
    end
    n_tests++;
    req_valid = 1'b1; node_idx = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({req_ready, rsp_valid, err} !== 3'b001) begin
        n_fail++; $display("FAIL regroup_req%0d: req_ready/rsp_valid/err=%b required 001", i, {req_ready, rsp_valid, err});
      end
      n_tests++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_degree_limit();
    do_reset();
    for (int i = 0; i < 15; i++) load_beat(2, 100 + i, i == 14);
    if ({err, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL deg15_load: err/req_ready=%b required 01", {err, req_ready});
    end
    n_tests++;
    issue_req(2);
    for (int i = 0; i < 15; i++) begin
      step();
      if (obs() !== beat(1, 100 + i, 15 - i)) begin
        n_fail++; $display("FAIL deg15_beat%0d: got %h required %h", i, obs(), beat(1, 100 + i, 15 - i));
      end
      n_tests++;
    end
    step();
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL deg15_done: req_ready=%b required 1", req_ready);
    end
    n_tests++;
    do_reset();
    for (int i = 0; i < 15; i++) load_beat(3, 200 + i, 1'b0);
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL deg16_pre: err=%b required 0", err);
    end
    n_tests++;
    load_beat(3, 215, 1'b1);
    if ({err, ld_ready, req_ready} !== 3'b100) begin
      n_fail++; $display("FAIL deg16_err: err/ld_ready/req_ready=%b required 100", {err, ld_ready, req_ready});
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    load_small_graph();
    issue_req(0);
    step();
    if (obs() !== beat(1, 1, 3)) begin
      n_fail++; $display("FAIL mid_beat0: got %h required %h", obs(), beat(1, 1, 3));
    end
    n_tests++;
    rst = 1'b1;
    step();
    if ({rsp_valid, err, ld_ready} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst: rsp_valid/err/ld_ready=%b required 000", {rsp_valid, err, ld_ready});
    end
    n_tests++;
    rst = 1'b0;
    #1;
    if ({ld_ready, req_ready, rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL mid_load: ld_ready/req_ready/rsp_valid=%b required 100", {ld_ready, req_ready, rsp_valid});
    end
    n_tests++;
    load_beat(7, 8, 1'b1);
    issue_req(0);
    step();
    if (obs() !== beat(1, 0, 0)) begin
      n_fail++; $display("FAIL reload_node0: got %h required %h", obs(), beat(1, 0, 0));
    end
    n_tests++;
    step();
    issue_req(7);
    step();
    if (obs() !== beat(1, 8, 1)) begin
      n_fail++; $display("FAIL reload_node7: got %h required %h", obs(), beat(1, 8, 1));
    end
    n_tests++;
    step();
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reload_done: req_ready/rsp_valid=%b required 10", {req_ready, rsp_valid});
    end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_unloaded();
    test_backpressure();
    test_regroup_error();
    test_degree_limit();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/graph_edge_server.md
# graph_edge_server

Graph adjacency responder for the path-counting accelerator. It is loaded once with an edge list grouped by source node. It then answers node lookups from the traversal controller by streaming each neighbour of the requested node, one beat per cycle, with a down-counter of remaining edges. It is the memory-side end of the `node_idx` / `next_node_idx` / `next_node_counter` interface driven by the control FSM.

## Interface
Parameters:
- PARAM_NODE_IDX_WIDTH, 10, width of node indices; node table depth is 2^PARAM_NODE_IDX_WIDTH
- PARAM_COUNTER_WIDTH, 4, width of edge counter; max out-degree is 2^PARAM_COUNTER_WIDTH-1
- PARAM_MAX_EDGES, 4096, edge array depth (power of two)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted
- ld_src_idx  in  NODE_IDX_W  source node of edge
- ld_dst_idx  in  NODE_IDX_W  destination node of edge
- ld_last  in  1  final edge of whole graph
- req_valid  in  1  lookup request
- req_ready  out  1  server idle and accepting lookups
- node_idx  in  NODE_IDX_W  node to look up
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  controller accepts beat
- next_node_idx  out  NODE_IDX_W  neighbour index
- next_node_counter  out  COUNTER_W  edges remaining including this beat; 0 means no edges
- err  out  1  sticky load error

## Operation
- FSM states: LOAD, SERVE_IDLE, LOOKUP, STREAM, ERROR.
- Reset → LOAD. All node-table valid bits cleared. Edge write pointer = 0. Outputs: ld_ready=0 during the reset cycle and 1 after it, req_ready=0, rsp_valid=0, next_node_idx=0, next_node_counter=0, err=0.
- LOAD: ld_ready=1. Each beat writes ld_dst_idx to edge[wr_ptr] and increments wr_ptr.
  - When ld_src_idx differs from the previous beat's source (or on the first beat), a new group opens: node_table[src] = {valid=1, offset=wr_ptr, count=0}.
  - Each beat increments the open group's count.
  - ld_last accepted → SERVE_IDLE.
- Load errors go to ERROR (err=1, ld_ready=0, req_ready=0, until rst). The offending beat is not written. Errors are:
  - a group opens for a source already valid;
  - count would exceed 2^COUNTER_W-1;
  - wr_ptr == PARAM_MAX_EDGES.
- SERVE_IDLE: req_ready=1. An accepted request latches node_idx → LOOKUP.
- LOOKUP: read the node table.
  - Invalid entry or count 0 → emit one beat: next_node_idx=0, counter=0.
  - Otherwise → STREAM with rd_ptr=offset, remaining=count.
- STREAM: rsp_valid=1, next_node_idx=edge[rd_ptr], next_node_counter=remaining.
  - On rsp_valid&rsp_ready: rd_ptr++ and remaining--.
  - When the beat accepted carried counter ≤1 → SERVE_IDLE.
- Outputs hold stable while rsp_valid=1 and rsp_ready=0.
- req_valid during LOAD, LOOKUP, STREAM or ERROR is ignored (req_ready=0).
- Counter arithmetic is unsigned COUNTER_W bits. offset and rd_ptr are $clog2(PARAM_MAX_EDGES) bits. No wrap is permitted in either.

## Timing
- Request accepted at cycle T. Node table is read with registered output at T+1. The first rsp beat is valid at T+2.
- With rsp_ready held high, a node of degree d streams beats T+2..T+d+1, and req_ready=1 at T+d+2.
- Zero-degree or unloaded node: the single beat is at T+2, and req_ready=1 at T+3.
- Edge RAM reads are prefetched: back-to-back beats are issued with no bubble.
- Load throughput is one edge per cycle. The first request may be accepted the cycle after ld_last is accepted.
- rst asserted mid-stream: the next cycle is LOAD with rsp_valid=0. All edges must be reloaded.

## Configuration
- GRAPH_EDGE_SERVER_STATS_EN defined: adds the following outputs, both cleared by rst and saturating:
  - stat_req_count (16 bits): incremented per accepted request;
  - stat_edge_count (16 bits): incremented per accepted nonzero-counter beat.
- Undefined: these ports and their registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package graph_pkg:
  - state enum graph_srv_state_t;
  - node-table entry struct {valid, offset, count};
  - default width constants shared with the controller.
- Sub-module sync_ram: single-port, registered read, write-first. It is instantiated twice, for the node table and the edge array. Node-table valid bits live in flops outside the RAM so they clear on reset.

## Test plan
- Load 0→{1,2,3}, 1→{3}, ld_last on the final edge. Request 0 with rsp_ready=1 → beats (1,3),(2,2),(3,1) at T+2..T+4, then req_ready=1 at T+5.
- After the same load, request node 5 (never loaded) → one beat (0,0) at T+2, req_ready=1 at T+3.
- Request 0 with rsp_ready low for 3 cycles on beat 2 → beat (2,2) held stable, then (3,1) follows; no beat lost or duplicated.
- Load sources 0,1,0 → err=1 on the third group's first beat, ld_ready=0; requests are never accepted.
- Load 16 edges from one source with COUNTER_W=4 → err=1 on the 16th edge. 15 edges → no error, first beat counter=15.
- Assert rst during a STREAM beat → next cycle rsp_valid=0, state LOAD, err=0. A request for a previously loaded node after reload of an empty graph returns (0,0).
